// File: rtl/float_addsub_pipe.sv
// Pipelined floating-point add/subtract, round-to-nearest-even, denormals flushed to zero.
// Latency: 3 cycles (unpack/align, add/normalise, round/pack); throughput one operation per clock.
// Backpressure: one shared enable stalls every stage while a result waits; in_ready mirrors that enable.
module float_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     op,
    input  logic [EXP_W+MAN_W:0]     v1,
    input  logic [EXP_W+MAN_W:0]     v2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     vres,
    output logic [3:0]               flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;            // hidden + fraction + guard/round/sticky
    localparam int XW  = EXP_W + 2;            // two's-complement exponent with headroom
    localparam int LZW = $clog2(SW + 1);
    localparam int unsigned ALIGN_MAX = SW - 1;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flg;
        logic             sign_a;
        logic             sign_b;
        logic [EXP_W-1:0] exp_a;
        logic [SW-1:0]    sig_a;
        logic [SW-1:0]    sig_b;
    } s1_t;

    typedef struct packed {
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flg;
        logic             zero;
        logic             sign;
        logic [XW-1:0]    exp_n;
        logic [SW-1:0]    sig_n;
    } s2_t;

    logic en;
    logic s1_vld, s2_vld;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic             sgn1, sgn2, nan1, nan2, snan1, snan2, inf1, inf2, swap;
    logic [EXP_W-1:0] e1, e2, exp_b, shamt;
    logic [MAN_W-1:0] f1, f2, m1, m2, ma, mb;
    logic [SW-1:0]    sig_b_raw, lost_mask;

    always_comb begin
        s1_d      = '0;
        e1        = v1[W-2 -: EXP_W];
        e2        = v2[W-2 -: EXP_W];
        f1        = v1[MAN_W-1:0];
        f2        = v2[MAN_W-1:0];
        sgn1      = v1[W-1];
        sgn2      = v2[W-1] ^ op;
        nan1      = (e1 == EXP_ONES) && (f1 != '0);
        nan2      = (e2 == EXP_ONES) && (f2 != '0);
        snan1     = nan1 && !f1[MAN_W-1];
        snan2     = nan2 && !f2[MAN_W-1];
        inf1      = (e1 == EXP_ONES) && (f1 == '0);
        inf2      = (e2 == EXP_ONES) && (f2 == '0);
        // Denormal inputs become zeros of the same sign.
        m1        = (e1 == '0) ? '0 : f1;
        m2        = (e2 == '0) ? '0 : f2;
        swap      = {e2, m2} > {e1, m1};
        ma        = swap ? m2 : m1;
        mb        = swap ? m1 : m2;
        exp_b     = swap ? e1 : e2;
        lost_mask = '0;

        s1_d.sign_a = swap ? sgn2 : sgn1;
        s1_d.sign_b = swap ? sgn1 : sgn2;
        s1_d.exp_a  = swap ? e2 : e1;
        s1_d.sig_a  = {s1_d.exp_a != '0, ma, 3'b000};
        sig_b_raw   = {exp_b != '0, mb, 3'b000};
        shamt       = s1_d.exp_a - exp_b;

        if (32'(shamt) >= ALIGN_MAX) begin
            s1_d.sig_b = {{(SW-1){1'b0}}, |sig_b_raw};
        end else begin
            lost_mask  = ~({SW{1'b1}} << shamt);
            s1_d.sig_b = (sig_b_raw >> shamt) | {{(SW-1){1'b0}}, |(sig_b_raw & lost_mask)};
        end

        s1_d.spec = nan1 || nan2 || inf1 || inf2;
        if (nan1 || nan2) begin
            s1_d.spec_res = QNAN;
            s1_d.spec_flg = {snan1 || snan2, 3'b000};
        end else if (inf1 && inf2 && (sgn1 != sgn2)) begin
            s1_d.spec_res = QNAN;
            s1_d.spec_flg = 4'b1000;
        end else if (inf1) begin
            s1_d.spec_res = {sgn1, EXP_ONES, {MAN_W{1'b0}}};
        end else if (inf2) begin
            s1_d.spec_res = {sgn2, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // ---------------- S2: add/subtract, normalise ----------------
    logic [SW:0]    sum;
    logic [LZW-1:0] lz;

    always_comb begin
        s2_d          = '0;
        s2_d.spec     = s1_q.spec;
        s2_d.spec_res = s1_q.spec_res;
        s2_d.spec_flg = s1_q.spec_flg;
        if (s1_q.sign_a ^ s1_q.sign_b)
            sum = {1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b};
        else
            sum = {1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b};

        lz = '0;
        for (int i = 0; i < SW; i++) begin
            if (sum[i]) lz = LZW'(SW - 1 - i);
        end

        s2_d.zero = (sum == '0);
        // Only two negative zeros can sum to -0; cancellation yields +0.
        s2_d.sign = s2_d.zero ? (s1_q.sign_a & s1_q.sign_b) : s1_q.sign_a;
        if (sum[SW]) begin
            s2_d.sig_n = {sum[SW:2], sum[1] | sum[0]};
            s2_d.exp_n = {2'b00, s1_q.exp_a} + XW'(1);
        end else begin
            s2_d.sig_n = sum[SW-1:0] << lz;
            s2_d.exp_n = {2'b00, s1_q.exp_a} - XW'(lz);
        end
    end

    // ---------------- S3: round, pack, flags ----------------
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] frac_r;
    logic [XW-1:0]    exp_r;
    logic             g_bit, r_bit, s_bit, rnd_up, inexact;
    logic [W-1:0]     res_d;
    logic [3:0]       flg_d;

    always_comb begin
        mant    = s2_q.sig_n[SW-1:3];
        g_bit   = s2_q.sig_n[2];
        r_bit   = s2_q.sig_n[1];
        s_bit   = s2_q.sig_n[0];
        inexact = g_bit | r_bit | s_bit;
        rnd_up  = g_bit & (r_bit | s_bit | mant[0]);
        mant_r  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd_up};
        exp_r   = s2_q.exp_n + {{(XW-1){1'b0}}, mant_r[MAN_W+1]};
        frac_r  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        res_d   = '0;
        flg_d   = '0;

        if (s2_q.spec) begin
            res_d = s2_q.spec_res;
            flg_d = s2_q.spec_flg;
        end else if (s2_q.zero) begin
            res_d = {s2_q.sign, {(W-1){1'b0}}};
        end else if (!exp_r[XW-1] && (exp_r[XW-2:0] >= {1'b0, EXP_ONES})) begin
            res_d = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
            flg_d = 4'b0101;
        end else if (exp_r[XW-1] || (exp_r == '0)) begin
            res_d = {s2_q.sign, {(W-1){1'b0}}};
            flg_d = 4'b0011;
        end else begin
            res_d = {s2_q.sign, exp_r[EXP_W-1:0], frac_r};
            flg_d = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
            vres      <= '0;
            flags     <= '0;
        end else if (en) begin
            s1_vld    <= in_valid;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (in_valid) s1_q <= s1_d;
            if (s1_vld)   s2_q <= s2_d;
            if (s2_vld) begin
                vres  <= res_d;
                flags <= flg_d;
            end
        end
    end
endmodule

// File: tb/tb_float_addsub_pipe.sv
// Directed-vector bench for float_addsub_pipe: single-precision table, backpressure,
// mid-flight reset and a half-precision build.
`timescale 1ns/1ps
module tb_float_addsub_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] v1, v2, vres;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
    logic [15:0] h_v1, h_v2, h_vres;
    logic [3:0]  h_flags;

    int checks   = 0;
    int failures = 0;

    float_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .v1(v1), .v2(v2), .out_valid(out_valid), .out_ready(out_ready),
        .vres(vres), .flags(flags)
    );

    float_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
        .v1(h_v1), .v2(h_v2), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .vres(h_vres), .flags(h_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic run_vec(input int idx);
        int lat;
        @(negedge clk);
        op = vecs[idx].op; v1 = vecs[idx].a; v2 = vecs[idx].b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'd3);
        chk($sformatf("vec%0d_vres", idx), vres, vecs[idx].res);
        chk($sformatf("vec%0d_flags", idx), 32'(flags), 32'(vecs[idx].flg));
    endtask

    task automatic run_half(input logic hop, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] res, input logic [3:0] flg, input string nm);
        int lat;
        @(negedge clk);
        h_op = hop; h_v1 = a; h_v2 = b; h_in_valid = 1'b1;
        @(posedge clk);
        #1 h_in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!h_out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd3);
        chk({nm, "_vres"}, 32'(h_vres), 32'(res));
        chk({nm, "_flags"}, 32'(h_flags), 32'(flg));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] exp_q[$];
        int sent, got, seen;

        vecs[0]  = '{1'b0, 32'h4145851F, 32'h40490FDA, 32'h4177C916, 4'b0001};
        vecs[1]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000};
        vecs[2]  = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000};
        vecs[3]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101};
        vecs[4]  = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000};
        vecs[5]  = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000};
        vecs[6]  = '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[7]  = '{1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000};
        vecs[8]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000};
        vecs[9]  = '{1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 4'b0000};
        vecs[10] = '{1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000};
        vecs[11] = '{1'b1, 32'h00C00000, 32'h00800000, 32'h00000000, 4'b0011};
        vecs[12] = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001};
        vecs[13] = '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001};
        vecs[14] = '{1'b1, 32'h3F800000, 32'h30800000, 32'h3F800000, 4'b0001};
        vecs[15] = '{1'b1, 32'h3F800000, 32'h3FC00000, 32'hBF000000, 4'b0000};
        vecs[16] = '{1'b1, 32'h3F800001, 32'h3F800000, 32'h34000000, 4'b0000};
        vecs[17] = '{1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0000};

        // Reset with an operand offered: it must not be taken.
        rst = 1'b1; in_valid = 1'b1; op = 1'b0; v1 = 32'h3F800000; v2 = 32'h3F800000;
        out_ready = 1'b1;
        h_in_valid = 1'b1; h_op = 1'b0; h_v1 = 16'h3C00; h_v2 = 16'h3C00; h_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_vres", vres, 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0; in_valid = 1'b0; h_in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid || h_out_valid) seen++;
        end
        chk("reset_no_accept", 32'(seen), 32'd0);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Back-to-back issue with the consumer stalled for five cycles.
        sent = 0; got = 0;
        exp_q.delete();
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 6);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                op = vecs[sent].op; v1 = vecs[sent].a; v2 = vecs[sent].b;
            end
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("bp_spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk($sformatf("bp_vres_%0d", got), vres, exp_q[0][35:4]);
                    chk($sformatf("bp_flags_%0d", got), 32'(flags), 32'(exp_q[0][3:0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end else begin
                        chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({vecs[sent].res, vecs[sent].flg});
                sent++;
            end
        end
        chk("bp_accepted", 32'(sent), 32'd5);
        chk("bp_delivered", 32'(got), 32'd5);
        in_valid = 1'b0; out_ready = 1'b1;

        // Reset with two operations in flight.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1; op = vecs[c].op; v1 = vecs[c].a; v2 = vecs[c].b;
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; op = vecs[4].op; v1 = vecs[4].a; v2 = vecs[4].b;
        #1 chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_vres", vres, 32'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_stale", 32'(seen), 32'd0);

        run_vec(0);

        run_half(1'b0, 16'h3C00, 16'h3C00, 16'h4000, 4'b0000, "half_add");
        run_half(1'b1, 16'h3C00, 16'h3C00, 16'h0000, 4'b0000, "half_cancel");
        run_half(1'b0, 16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101, "half_ovf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
